// File: rtl/music_pkg.sv
// music_pkg: shared constants and player state type for the song sample players.
package music_pkg;
    localparam logic [7:0] SAMPLE_MID = 8'h80;
    localparam int MUSIC0_CLK_DIV = 12500;
    localparam int MUSIC0_SAMPLE_LEN = 200000;
    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} player_state_t;
endpackage

// File: rtl/music_sample_player_if.sv
// music_sample_player_if: block ROM read port between the player and the song ROM.
interface music_sample_player_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
);
    logic rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    modport master(output rom_en, rom_addr, input rom_data);
    modport slave(input rom_en, rom_addr, output rom_data);
endinterface

// File: rtl/pwm_dac.sv
// pwm_dac: free-running PWM DAC; duty is latched at counter wrap so each period is glitch-free.
module pwm_dac #(
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_WIDTH-1:0] duty,
    output logic pwm
);
    logic [DATA_WIDTH-1:0] cnt, duty_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            duty_q <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (&cnt) duty_q <= duty;
        end
    end
    assign pwm = cnt < duty_q;
endmodule

// File: rtl/music_sample_player.sv
// music_sample_player: paces ROM sample fetches at a fixed rate with play/pause/stop/loop
// control, absorbs the ROM read latency, and drives a PWM audio pin.
module music_sample_player import music_pkg::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLE_LEN = MUSIC0_SAMPLE_LEN,
    parameter int CLK_DIV = MUSIC0_CLK_DIV,
    parameter int ROM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic play,
    input  logic pause,
    input  logic stop,
    input  logic loop_en,
    music_sample_player_if.master rom,
    output logic [DATA_WIDTH-1:0] sample,
    output logic sample_valid,
    output logic playing,
    output logic done,
    output logic audio_pwm
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(SAMPLE_MID);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SAMPLE_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    player_state_t state, state_n;
    logic [DIV_W-1:0] div;
    logic [ADDR_WIDTH-1:0] pos, addr_q;
    logic [ROM_LATENCY-1:0] vld, endq;
    logic fetch, last, song_end, capture;

    assign fetch = state == PLAY && div == '0;
    assign last = pos == LAST;
    assign song_end = fetch && last && !loop_en;
    // stop discards a capture landing in the same cycle
    assign capture = vld[ROM_LATENCY-1] && !stop;
    assign rom.rom_en = fetch;
    assign rom.rom_addr = fetch ? pos : addr_q;
    assign sample_valid = capture;
    assign done = capture && endq[ROM_LATENCY-1];
    assign playing = state == PLAY;

    always_comb begin
        state_n = stop || done ? IDLE :
                  play && state != PLAY ? PLAY :
                  pause && state == PLAY ? PAUSE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div <= '0;
            pos <= '0;
            addr_q <= '0;
            vld <= '0;
            endq <= '0;
            sample <= MID;
        end else begin
            state <= state_n;
            vld <= stop ? '0 : (vld << 1) | ROM_LATENCY'(fetch);
            endq <= stop ? '0 : (endq << 1) | ROM_LATENCY'(song_end);
            if (fetch) addr_q <= pos;
            // divider runs only in PLAY, so pause freezes it at its current count
            div <= stop || state == IDLE ? '0 :
                   state == PLAY ? (div == DIV_MAX ? '0 : div + 1'b1) : div;
            pos <= stop || state == IDLE ? '0 :
                   fetch ? (last ? '0 : pos + 1'b1) : pos;
            sample <= stop ? MID : capture ? rom.rom_data : state == IDLE ? MID : sample;
        end
    end

    pwm_dac #(.DATA_WIDTH(DATA_WIDTH)) u_dac (
        .clk(clk),
        .rst(rst),
        .duty(sample),
        .pwm(audio_pwm)
    );
endmodule

// File: tb/tb_music_sample_player.sv
// tb_music_sample_player: directed and randomized song playback checked against an arithmetic model.
module tb_music_sample_player;
    import music_pkg::*;
    localparam int AW = 32, DW = 8, SL = 4, CD = 4, RL = 1;

    logic clk = 0, rst = 1, play = 0, pause = 0, stop = 0, loop_en = 0;
    logic [DW-1:0] sample;
    logic sample_valid, playing, done, audio_pwm;

    music_sample_player_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rom();

    music_sample_player #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SAMPLE_LEN(SL), .CLK_DIV(CD), .ROM_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .loop_en(loop_en),
        .rom(rom), .sample(sample), .sample_valid(sample_valid), .playing(playing),
        .done(done), .audio_pwm(audio_pwm)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom.rom_en) rom.rom_data <= 8'h10 + rom.rom_addr[7:0];

    int total = 0, bad = 0, cyc = 0, pcyc = 0;
    int fa[$], fc[$], fp[$], vc[$], vd[$], dc[$];
    int en_off = 0, last_done = -100;
    logic [31:0] dplay, dsample;
    bit vpend = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vpend) begin vd.push_back(int'(sample)); vpend = 0; end
        if (rom.rom_en) begin
            fa.push_back(int'(rom.rom_addr));
            fc.push_back(cyc);
            fp.push_back(pcyc);
            if (!playing) en_off++;
        end
        if (sample_valid) begin vc.push_back(cyc); vpend = 1; end
        if (done) begin dc.push_back(cyc); last_done = cyc; end
        if (cyc == last_done + 1) dplay = 32'(playing);
        if (cyc == last_done + 2) dsample = 32'(sample);
        if (playing) pcyc++;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_play();
        play = 1; tick(1); play = 0;
    endtask

    task automatic clearq();
        fa.delete(); fc.delete(); fp.delete(); vc.delete(); vd.delete(); dc.delete();
        en_off = 0; dplay = 1; dsample = 0;
    endtask

    task automatic chk_reset(string tag);
        @(negedge clk);
        chk({tag, "_en"}, 32'(rom.rom_en), 0);
        chk({tag, "_addr"}, rom.rom_addr, 0);
        chk({tag, "_sample"}, 32'(sample), 32'h80);
        chk({tag, "_valid"}, 32'(sample_valid), 0);
        chk({tag, "_playing"}, 32'(playing), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pwm"}, 32'(audio_pwm), 0);
    endtask

    // Plays one song from idle; optional pause of pl cycles starting pc cycles after play.
    task automatic song(bit lp, bit dp, int pc, int pl);
        int e, t, n;
        clearq();
        loop_en = lp;
        pulse_play();
        e = cyc;
        for (t = 0; t < 500; t++) begin
            if (dp && t == pc) pause = 1;
            if (dp && t == pc + 1) pause = 0;
            if (dp && t == pc + 1 + pl) play = 1;
            if (dp && t == pc + 2 + pl) play = 0;
            if (!lp && dc.size() > 0 && cyc >= last_done + 3) break;
            if (lp && vd.size() >= 6) break;
            tick(1);
        end
        pause = 0; play = 0;
        if (lp) begin stop = 1; tick(1); stop = 0; tick(2); end
        chk("song_timeout", 32'(t < 500), 1);
        n = vd.size();
        if (fc.size() > 0) chk("first_fetch_cyc", fc[0], e);
        for (int i = 0; i < n; i++) begin
            chk("fetch_addr", fa[i], i % SL);
            chk("valid_latency", vc[i], fc[i] + RL);
            chk("sample_val", vd[i], 8'h10 + (i % SL));
            if (i > 0) chk("fetch_spacing", fp[i] - fp[i-1], CD);
        end
        chk("en_while_not_playing", en_off, 0);
        if (!lp) begin
            chk("song_len", n, SL);
            chk("done_count", dc.size(), 1);
            if (dc.size() > 0 && vc.size() >= SL) chk("done_with_last", dc[0], vc[SL-1]);
            chk("playing_after_done", dplay, 0);
            chk("sample_after_done", dsample, 32'h80);
        end else begin
            chk("loop_no_done", dc.size(), 0);
        end
    endtask

    initial begin
        int hi, e;
        tick(3);
        chk_reset("reset");
        tick(1);
        rst = 0;

        clearq();
        tick(300);
        chk("idle_no_fetch", fa.size(), 0);
        @(negedge clk);
        chk("idle_sample", 32'(sample), 32'h80);
        hi = 0;
        repeat (256) begin @(negedge clk); hi += int'(audio_pwm); end
        chk("idle_duty", hi, 128);
        tick(1);

        song(0, 0, 0, 0);
        song(1, 0, 0, 0);
        song(0, 1, 4, 20);
        for (int ep = 0; ep < 6; ep++)
            song(ep[0], 1'b1, $urandom_range(0, 7), $urandom_range(1, 30));

        clearq();
        loop_en = 0;
        pulse_play();
        e = cyc;
        while (cyc < e + 2 * CD) tick(1);
        stop = 1; tick(1); stop = 0;
        tick(3);
        chk("stop_fetches", fa.size(), 3);
        chk("stop_no_valid", vc.size(), 2);
        @(negedge clk);
        chk("stop_sample", 32'(sample), 32'h80);
        chk("stop_playing", 32'(playing), 0);
        tick(1);
        clearq();
        pulse_play();
        tick(2);
        chk("restart_fetch_cnt", fa.size(), 1);
        if (fa.size() > 0) chk("restart_addr", fa[0], 0);

        tick(5);
        play = 1; stop = 1; tick(1); play = 0; stop = 0;
        @(negedge clk);
        chk("playstop_playing", 32'(playing), 0);
        chk("playstop_sample", 32'(sample), 32'h80);
        tick(1);
        clearq();
        pulse_play();
        tick(1);
        if (fa.size() > 0) chk("playstop_pos0", fa[0], 0);
        else chk("playstop_fetch", 0, 1);

        tick(6);
        rst = 1; tick(1);
        chk_reset("midsong_rst");
        tick(1);
        rst = 0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/music_sample_player.md
# music_sample_player

Sequencer for the `music0` song-audio block ROM: 8-bit data, one address per audio sample. It issues ROM reads at a fixed sample rate and handles the ROM read latency. It supports play, pause, stop and loop, presents each fetched sample with a valid strobe, and drives a PWM audio pin through a small DAC sub-module. The block sits between the game-control FSM (play/stop commands) and the board audio output.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: ROM address width; matches `music0` `addra`.
- `DATA_WIDTH`, 8: ROM data and sample width.
- `SAMPLE_LEN`, 200000: number of samples; valid addresses are 0..SAMPLE_LEN-1.
- `CLK_DIV`, 12500: clk cycles per sample (100 MHz / 8 kHz). Must be > `ROM_LATENCY`+1.
- `ROM_LATENCY`, 1: cycles from `rom_en`/`rom_addr` to valid `rom_data`.

Ports:
- `clk`, in, 1: system clock, 100 MHz; also drives ROM `clka`.
- `rst`, in, 1: synchronous, active-high reset.
- `play`, in, 1: one-cycle pulse; start from 0 if idle, resume if paused.
- `pause`, in, 1: one-cycle pulse; hold position.
- `stop`, in, 1: one-cycle pulse; abort and return to idle, position 0.
- `loop_en`, in, 1: level; sampled at end of song.
- `rom_en`, out, 1: ROM `ena`; high only on fetch cycles.
- `rom_addr`, out, ADDR_WIDTH: ROM `addra`.
- `rom_data`, in, DATA_WIDTH: ROM `douta`.
- `sample`, out, DATA_WIDTH: current unsigned sample; midline 8'h80 when idle.
- `sample_valid`, out, 1: one-cycle pulse when `sample` updates from ROM.
- `playing`, out, 1: high in PLAY.
- `done`, out, 1: one-cycle pulse at non-looping end of song.
- `audio_pwm`, out, 1: PWM output.

## Operation
- States: IDLE, PLAY, PAUSE. An in-flight fetch is tracked by a `ROM_LATENCY`-deep valid shift register, not by separate states.
- Command priority within one cycle: `stop` > `play` > `pause`.
- IDLE + `play`: position `pos`=0, divider counter cleared, first fetch issued the next cycle, state goes to PLAY.
- PLAY:
  - Divider counts 0..CLK_DIV-1. At count 0, `rom_en`=1 and `rom_addr`=`pos` for one cycle.
  - `ROM_LATENCY` cycles later, `sample`<=`rom_data` and `sample_valid`=1.
  - After each fetch: if `pos`==SAMPLE_LEN-1, then with `loop_en`=1 set `pos`<=0 and keep playing; with `loop_en`=0 go to IDLE after capture, pulse `done` with that sample's `sample_valid`, and set `sample`<=8'h80 the cycle after. Otherwise `pos`<=`pos`+1.
- PLAY + `pause`: go to PAUSE. An in-flight fetch still completes and captures. `sample` holds its last value and the divider freezes.
- PAUSE + `play`: return to PLAY; the divider resumes from its frozen count.
- PAUSE + `pause`, and PLAY + `play`: ignored.
- `stop` in any state: go to IDLE, `pos`=0, divider cleared, in-flight capture discarded, `sample`<=8'h80, no `done`.
- `pos` is `ADDR_WIDTH` wide. Compare with `==` only; it never exceeds SAMPLE_LEN-1.

## Timing
- Reset values: state IDLE, `rom_en`=0, `rom_addr`=0, `sample`=8'h80, `sample_valid`=0, `playing`=0, `done`=0, `audio_pwm`=0, divider=0, `pos`=0.
- Reset mid-song behaves like `stop` but also zeroes the PWM counter.
- `play` accepted at edge E. Then:
  - `rom_en`=1 during cycle E+1.
  - `sample_valid`=1 in cycle E+1+ROM_LATENCY.
  - Subsequent fetches every `CLK_DIV` cycles while in PLAY.
- `playing` is registered; it rises the cycle after `play` is accepted.
- `rom_addr` holds its last value when `rom_en`=0.
- PWM: 8-bit free-running counter; `audio_pwm`=(counter < `sample`). Period 256 clk; duty updates at counter wrap.

## Structure
- Shared package `music_pkg`:
  - `SAMPLE_MID`=8'h80.
  - Player state enum {IDLE, PLAY, PAUSE}.
  - Default `CLK_DIV` and `SAMPLE_LEN` constants per song ROM.
- Sub-module `pwm_dac`: inputs `clk`, `rst`, duty[DATA_WIDTH-1:0]; output `pwm`. Duty is latched at counter wrap.
- The ROM (`music0`) is instantiated at the top level, not inside this block.

## Test plan
Test parameters: SAMPLE_LEN=4, CLK_DIV=4, ROM_LATENCY=1. Behavioural ROM model returns data = 8'h10+addr.
- Reset then idle 20 cycles -> `rom_en` never high, `sample`=8'h80, `audio_pwm` duty 128/256.
- `play`, `loop_en`=0 -> fetches addr 0,1,2,3 spaced 4 cycles apart; `sample_valid` delivers 10,11,12,13. `done` coincides with 13. `sample`=80 next cycle; `playing` falls.
- `loop_en`=1 -> address sequence 0,1,2,3,0,1; no `done`.
- `pause` after addr 1 fetch, wait 20 cycles, then `play` -> sample 11 still captured; no `rom_en` while paused; next fetch is addr 2, exactly 4 divider cycles of PLAY after the previous one.
- `stop` in the same cycle as `rom_en` for addr 2 -> no `sample_valid`, `sample`=80. A following `play` fetches addr 0.
- `play` and `stop` in the same cycle from PLAY -> stop wins: IDLE, `pos`=0. Assert `rst` mid-song -> all outputs equal their reset values next cycle.
